// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and widths for the UART receive-side buffer
package uart_pkg;
   localparam int UART_DATA_WIDTH = 8;

   typedef enum logic {
      CAP_IDLE = 1'b0,
      CAP_ACK  = 1'b1
   } cap_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module uart_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic                      wr_en,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      rd_en,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count_q;
   logic                  do_wr;
   logic                  do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_COUNT);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr];

   // A write into a full FIFO is legal only when the head leaves at the same edge.
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - captures receiver frames into a FIFO, acks them, flags overrun
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_done,
   output logic                      clr_rx_done,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overrun,
   input  logic                      clr_overrun
);
   cap_state_t state;
   cap_state_t state_nx;
   logic       frame;
   logic       pop;
   logic       full;
   logic       empty;
   logic       accept;
   logic       drop;

   // A frame is taken only on entry from idle, so a long rx_done yields one write.
   assign frame  = (state == CAP_IDLE) & rx_done;
   assign pop    = rd_valid & rd_ready;
   assign accept = frame & (~full | pop);
   assign drop   = frame & full & ~pop;

   assign rd_valid    = ~empty;
   assign clr_rx_done = (state == CAP_ACK);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= CAP_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         CAP_IDLE: if (rx_done)  state_nx = CAP_ACK;
         CAP_ACK:  if (!rx_done) state_nx = CAP_IDLE;
         default:  state_nx = CAP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_l   (rst_l),
      .wr_en   (accept),
      .wr_data (rx_data),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );
endmodule
